// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester handshakes, SPI pins and receive port of the arbiter
interface spi_master_arbiter_if #(parameter int DATA_W = 16);
    logic              req0, ack0, req1, ack1;
    logic [DATA_W-1:0] data0, data1, rx_data;
    logic              CKP, CPH, SCK, SS, MOSI, MISO;
    logic              rx_valid, rx_src, busy;
    modport master (
        input  req0, data0, req1, data1, CKP, CPH, MISO,
        output ack0, ack1, SCK, SS, MOSI, rx_data, rx_valid, rx_src, busy
    );
    modport slave (
        output req0, data0, req1, data1, CKP, CPH, MISO,
        input  ack0, ack1, SCK, SS, MOSI, rx_data, rx_valid, rx_src, busy
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin SPI master sharing one bus between two requesters
module spi_master_arbiter #(
    parameter int DATA_W   = 16,
    parameter int DIV      = 2,
    parameter int IDLE_GAP = 2
) (
    input logic                  clk,
    input logic                  reset,
    spi_master_arbiter_if.master bus
);
    localparam int CMAX = (DIV > IDLE_GAP) ? DIV : IDLE_GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int EW   = $clog2(2 * DATA_W + 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [EW-1:0]     edge_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr, din;
    logic              sck, ss, mosi, cph_l, owner, last_gnt;
    logic              tick, gap_done, last_edge, shift_tick, sample_e, drive_e;
    logic              grant, win, hold_done, gap_exit;
    assign bus.SCK  = sck;
    assign bus.SS   = ss;
    assign bus.MOSI = mosi;
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    // next-state: each timed phase advances when its cycle counter expires
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = grant ? SETUP : IDLE;
            SETUP:   nxt = tick ? SHIFT : SETUP;
            SHIFT:   nxt = (tick && last_edge) ? HOLD : SHIFT;
            HOLD:    nxt = tick ? GAP : HOLD;
            GAP:     nxt = gap_done ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
    end
    // control decode; edge_cnt is 0-based so even counts are leading SCK edges
    always_comb begin
        tick       = cnt == CW'(DIV - 1);
        gap_done   = cnt == CW'(IDLE_GAP - 1);
        last_edge  = edge_cnt == EW'(2 * DATA_W - 1);
        shift_tick = (state == SHIFT) && tick;
        sample_e   = shift_tick && (cph_l ? edge_cnt[0] : ~edge_cnt[0]);
        drive_e    = shift_tick && (cph_l ? ~edge_cnt[0] : (edge_cnt[0] && !last_edge));
        grant      = (state == IDLE) && (bus.req0 || bus.req1);
        win        = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
        din        = win ? bus.data1 : bus.data0;
        hold_done  = (state == HOLD) && tick;
        gap_exit   = (state == GAP) && gap_done;
    end
    // datapath: SPI pins, shifters, handshakes and receive port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            edge_cnt     <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            sck          <= 1'b0;
            ss           <= 1'b1;
            mosi         <= 1'b0;
            cph_l        <= 1'b0;
            owner        <= 1'b0;
            last_gnt     <= 1'b1;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.rx_src   <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            cnt          <= (state != nxt || state == IDLE || shift_tick) ? '0 : cnt + 1'b1;
            edge_cnt     <= grant ? '0 : (shift_tick ? edge_cnt + 1'b1 : edge_cnt);
            sck          <= (state == IDLE) ? bus.CKP : (shift_tick ? ~sck : sck);
            bus.ack0     <= grant && !win;
            bus.ack1     <= grant && win;
            bus.rx_valid <= hold_done;
            bus.busy     <= grant ? 1'b1 : (gap_exit ? 1'b0 : bus.busy);
            if (grant) begin
                ss       <= 1'b0;
                owner    <= win;
                last_gnt <= win;
                cph_l    <= bus.CPH;
                tx_sr    <= bus.CPH ? din : {din[DATA_W-2:0], 1'b0};
                mosi     <= ~bus.CPH & din[DATA_W-1];
            end
            if (drive_e) begin
                mosi  <= tx_sr[DATA_W-1];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (sample_e) rx_sr <= {rx_sr[DATA_W-2:0], bus.MISO};
            if (hold_done) begin
                ss          <= 1'b1;
                mosi        <= 1'b0;
                bus.rx_data <= rx_sr;
                bus.rx_src  <= owner;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: scoreboard bench for the two-requester SPI master
module tb_spi_master_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    int   errors = 0, checks = 0;
    spi_master_arbiter_if #(.DATA_W(16)) bus();
    spi_master_arbiter #(.DATA_W(16), .DIV(2), .IDLE_GAP(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // bench SPI slave: returns s_word, captures MOSI into s_rx
    logic        loop = 1'b1, s_ckp = 1'b0, s_cph = 1'b0, s_miso = 1'b0;
    logic [15:0] s_word = 16'hA55A, s_sh = '0, s_rx = '0;
    assign bus.MISO = loop ? bus.MOSI : s_miso;
    always @(negedge bus.SS) begin
        s_rx   = '0;
        s_sh   = s_cph ? s_word : {s_word[14:0], 1'b0};
        s_miso = ~s_cph & s_word[15];
    end
    always @(bus.SCK) begin
        if (bus.SS === 1'b0 && reset === 1'b0) begin
            if ((bus.SCK !== s_ckp) ^ s_cph) s_rx = {s_rx[14:0], bus.MOSI};
            else begin
                #1;
                s_miso = s_sh[15];
                s_sh   = {s_sh[14:0], 1'b0};
            end
        end
    end

    // monitors and scoreboard: expected {rx_src, rx_data} popped on each rx_valid
    logic [16:0] sb[$];
    logic [16:0] sb_exp;
    int   rv_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, rises = 0;
    int   ss_run = 0, ss_len = 0, hi_run = 0, min_gap = 1000;
    logic sck_prev = 1'b0, ss_prev = 1'b1;
    always @(negedge clk) begin
        if (bus.ack0 === 1'b1) ack0_cnt++;
        if (bus.ack1 === 1'b1) ack1_cnt++;
        if (bus.SS === 1'b0) begin
            if (ss_prev !== 1'b0) begin
                rises = 0;
                ss_run = 0;
                if (hi_run < min_gap) min_gap = hi_run;
            end
            ss_run++;
            if (bus.SCK === 1'b1 && sck_prev === 1'b0) rises++;
        end else begin
            if (ss_prev === 1'b0) begin
                ss_len = ss_run;
                hi_run = 0;
            end
            hi_run++;
        end
        if (bus.rx_valid === 1'b1) begin
            rv_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got src=%0d data=%h, required no rx_valid", bus.rx_src, bus.rx_data);
            end else begin
                sb_exp = sb.pop_front();
                if ({bus.rx_src, bus.rx_data} !== sb_exp) begin
                    errors++;
                    $display("FAIL rx_word: got src=%0d data=%h, required src=%0d data=%h",
                             bus.rx_src, bus.rx_data, sb_exp[16], sb_exp[15:0]);
                end
            end
        end
        sck_prev = bus.SCK;
        ss_prev  = bus.SS;
    end

    task automatic start_frame(input bit src, input logic [15:0] d, output bit ok);
        int n = 0;
        if (src) begin bus.data1 = d; bus.req1 = 1'b1; end
        else begin bus.data0 = d; bus.req0 = 1'b1; end
        do begin @(negedge clk); n++; end
        while (!(src ? bus.ack1 === 1'b1 : bus.ack0 === 1'b1) && n < 300);
        ok = src ? bus.ack1 === 1'b1 : bus.ack0 === 1'b1;
        if (src) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.busy !== 1'b0 && n < 300);
        ok = bus.busy === 1'b0;
    endtask

    task automatic run_frame(input bit src, input logic [15:0] d, output bit ok);
        bit a, b;
        start_frame(src, d, a);
        wait_idle(b);
        ok = a && b;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.SS, bus.SCK, bus.MOSI, bus.ack0, bus.ack1, bus.rx_valid, bus.rx_src, bus.busy} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got SS,SCK,MOSI,ack0,ack1,rv,src,busy=%b, required 10000000",
                     {bus.SS, bus.SCK, bus.MOSI, bus.ack0, bus.ack1, bus.rx_valid, bus.rx_src, bus.busy});
        end
        checks++;
        if (bus.rx_data !== 16'h0) begin errors++; $display("FAIL reset_rx_data: got %h, required 0000", bus.rx_data); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.SCK !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got SCK=%b busy=%b, required 0 0", bus.SCK, bus.busy);
        end
    endtask

    task automatic test_mode0_loop;
        int a0 = ack0_cnt, r0 = rv_cnt;
        bit ok;
        loop = 1'b1; bus.CKP = 1'b0; bus.CPH = 1'b0; s_ckp = 1'b0; s_cph = 1'b0;
        sb.push_back({1'b0, 16'h0702});
        run_frame(1'b0, 16'h0702, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mode0_timeout: got done=0, required 1"); end
        checks++;
        if (ack0_cnt - a0 != 1) begin errors++; $display("FAIL mode0_ack0: got %0d pulses, required 1", ack0_cnt - a0); end
        checks++;
        if (rises != 16) begin errors++; $display("FAIL mode0_sck_rises: got %0d, required 16", rises); end
        checks++;
        if (ss_len != 68) begin errors++; $display("FAIL mode0_ss_low: got %0d cycles, required 68", ss_len); end
        checks++;
        if (rv_cnt - r0 != 1) begin errors++; $display("FAIL mode0_rx_valid: got %0d pulses, required 1", rv_cnt - r0); end
    endtask

    task automatic test_modes;
        bit ok;
        for (int m = 1; m < 4; m++) begin
            loop = 1'b0; s_word = 16'hA55A;
            s_ckp = m[1]; s_cph = m[0];
            bus.CKP = m[1]; bus.CPH = m[0];
            repeat (3) @(negedge clk);
            checks++;
            if (bus.SCK !== s_ckp) begin errors++; $display("FAIL mode%0d_sck_idle_pre: got %b, required %b", m, bus.SCK, s_ckp); end
            sb.push_back({1'b1, 16'hA55A});
            run_frame(1'b1, 16'h1234, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL mode%0d_timeout: got done=0, required 1", m); end
            checks++;
            if (s_rx !== 16'h1234) begin errors++; $display("FAIL mode%0d_slave_rx: got %h, required 1234", m, s_rx); end
            checks++;
            if (bus.SCK !== s_ckp) begin errors++; $display("FAIL mode%0d_sck_idle_post: got %b, required %b", m, bus.SCK, s_ckp); end
            checks++;
            if (ss_len != 68) begin errors++; $display("FAIL mode%0d_ss_low: got %0d cycles, required 68", m, ss_len); end
        end
    endtask

    task automatic test_round_robin;
        bit order[4];
        int k = 0, n = 0;
        bit ok;
        loop = 1'b1; bus.CKP = 1'b0; bus.CPH = 1'b0; s_ckp = 1'b0; s_cph = 1'b0;
        repeat (3) @(negedge clk);
        min_gap = 1000;
        bus.data0 = 16'hC3C3; bus.data1 = 16'h5A0F;
        for (int i = 0; i < 4; i++) sb.push_back(i[0] ? {1'b1, 16'h5A0F} : {1'b0, 16'hC3C3});
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        while (k < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                order[k] = bus.ack1;
                k++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        checks++;
        if (k != 4) begin errors++; $display("FAIL rr_grants: got %0d, required 4", k); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== i[0]) begin errors++; $display("FAIL rr_order%0d: got %0d, required %0d", i, order[i], i[0]); end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout: got done=0, required 1"); end
        checks++;
        if (min_gap < 2) begin errors++; $display("FAIL rr_ss_gap: got %0d cycles, required >=2", min_gap); end
    endtask

    task automatic test_ckp_mid;
        bit a, b;
        loop = 1'b1; bus.CKP = 1'b0; bus.CPH = 1'b0; s_ckp = 1'b0; s_cph = 1'b0;
        sb.push_back({1'b0, 16'h3C96});
        start_frame(1'b0, 16'h3C96, a);
        repeat (20) @(negedge clk);
        bus.CKP = 1'b1;
        wait_idle(b);
        checks++;
        if (!(a && b)) begin errors++; $display("FAIL ckp_mid_timeout: got done=0, required 1"); end
        checks++;
        if (rises != 16) begin errors++; $display("FAIL ckp_mid_rises: got %0d, required 16", rises); end
        checks++;
        if (bus.SCK !== 1'b0) begin errors++; $display("FAIL ckp_mid_latched_idle: got %b, required 0", bus.SCK); end
        @(negedge clk);
        checks++;
        if (bus.SCK !== 1'b1) begin errors++; $display("FAIL ckp_mid_new_idle: got %b, required 1", bus.SCK); end
        bus.CKP = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pulse;
        int a1 = ack1_cnt, r0 = rv_cnt;
        bit a, b;
        sb.push_back({1'b0, 16'h0F0F});
        start_frame(1'b0, 16'h0F0F, a);
        repeat (10) @(negedge clk);
        bus.req1 = 1'b1;
        @(negedge clk);
        bus.req1 = 1'b0;
        wait_idle(b);
        repeat (80) @(negedge clk);
        checks++;
        if (!(a && b)) begin errors++; $display("FAIL pulse_timeout: got done=0, required 1"); end
        checks++;
        if (ack1_cnt != a1) begin errors++; $display("FAIL pulse_ack1: got %0d pulses, required 0", ack1_cnt - a1); end
        checks++;
        if (rv_cnt - r0 != 1) begin errors++; $display("FAIL pulse_frames: got %0d, required 1", rv_cnt - r0); end
        checks++;
        if (bus.busy !== 1'b0 || bus.SS !== 1'b1) begin
            errors++;
            $display("FAIL pulse_idle: got busy=%b SS=%b, required 0 1", bus.busy, bus.SS);
        end
    endtask

    task automatic test_reset_mid;
        int e = 0, n = 0, r0;
        logic p;
        bit a, ok;
        start_frame(1'b0, 16'hBEEF, a);
        p = bus.SCK;
        while (e < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.SCK !== p) begin e++; p = bus.SCK; end
        end
        checks++;
        if (!a || e != 10) begin errors++; $display("FAIL rmid_reach_edge10: got edges=%0d ack=%0d, required 10 1", e, a); end
        r0 = rv_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.SS, bus.SCK, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL rmid_abort: got SS,SCK,busy=%b, required 100", {bus.SS, bus.SCK, bus.busy});
        end
        bus.data0 = 16'h6DB6; bus.req0 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rv_cnt != r0 || bus.ack0 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_no_output: got rv=%0d ack0=%b, required 0 0", rv_cnt - r0, bus.ack0);
        end
        sb.push_back({1'b0, 16'h6DB6});
        reset = 1'b0;
        run_frame(1'b0, 16'h6DB6, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_resume_timeout: got done=0, required 1"); end
        checks++;
        if (rv_cnt - r0 != 1) begin errors++; $display("FAIL rmid_resume_frames: got %0d, required 1", rv_cnt - r0); end
        checks++;
        if (ss_len != 68) begin errors++; $display("FAIL rmid_ss_low: got %0d cycles, required 68", ss_len); end
    endtask

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.data0 = '0; bus.data1 = '0;
        bus.CKP = 1'b0; bus.CPH = 1'b0;
        test_reset;
        test_mode0_loop;
        test_modes;
        test_round_robin;
        test_ckp_mid;
        test_pulse;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending words, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
